// File: rtl/pc_target_table.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_table
// Brief    : Multi-bank branch-target table with registered lookup, write-
//            through bypass and a sequential per-bank clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_table #(
    parameter  int D     = 12,
    parameter  int A     = 5,
    parameter  int BANKS = 2,
    localparam int B     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         rd_en,
    input  logic [B-1:0] bank_sel,
    input  logic [A-1:0] addr,
    output logic [D-1:0] target,
    output logic         rd_valid,
    output logic         hit,
    input  logic         wr_en,
    input  logic [B-1:0] wr_bank,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    output logic         wr_err,
    input  logic         clr_req,
    input  logic [B-1:0] clr_bank,
    output logic         busy,
    output logic         clr_done
);

    localparam int           DEPTH    = 2**A;
    localparam logic [A-1:0] LAST_IDX = {A{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [B-1:0]   clr_bank_q, clr_bank_d;
    logic [A-1:0]   cnt_q, cnt_d;

    logic [D-1:0]     mem_q   [0:BANKS-1][0:DEPTH-1];
    logic [DEPTH-1:0] valid_q [0:BANKS-1];

    logic [D-1:0]   target_q;
    logic           rd_valid_q;
    logic           hit_q;
    logic           wr_err_q;

    logic           rd_bank_ok, wr_bank_ok, clr_bank_ok;
    logic           wr_blocked, wr_ok, wr_rej;
    logic           rd_hit_d;
    logic [D-1:0]   rd_data_d;

    // Bank indices can only exceed BANKS when BANKS is not a power of two.
    generate
        if (BANKS == 2**B) begin : g_pow2_banks
            assign rd_bank_ok  = 1'b1;
            assign wr_bank_ok  = 1'b1;
            assign clr_bank_ok = 1'b1;
        end else begin : g_npow2_banks
            assign rd_bank_ok  = (32'(bank_sel) < BANKS);
            assign wr_bank_ok  = (32'(wr_bank)  < BANKS);
            assign clr_bank_ok = (32'(clr_bank) < BANKS);
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        clr_bank_d = clr_bank_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;
        clr_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req && clr_bank_ok) begin
                    state_d    = ST_CLEAR;
                    clr_bank_d = clr_bank;
                    cnt_d      = '0;
                end
            end
            ST_CLEAR: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    clr_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Index 0 is reserved: such writes vanish without raising an error.
    assign wr_blocked = (state_q == ST_CLEAR) && (wr_bank == clr_bank_q);
    assign wr_ok      = wr_en && wr_bank_ok && (wr_addr != '0) && !wr_blocked;
    assign wr_rej     = wr_en && (wr_addr != '0) && (!wr_bank_ok || wr_blocked);

    always_comb begin
        rd_hit_d  = 1'b0;
        rd_data_d = '0;
        if (wr_ok && (wr_bank == bank_sel) && (wr_addr == addr)) begin
            rd_hit_d  = 1'b1;
            rd_data_d = wr_data;
        end else if (rd_bank_ok && valid_q[bank_sel][addr]) begin
            rd_hit_d  = 1'b1;
            rd_data_d = mem_q[bank_sel][addr];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            clr_bank_q <= '0;
            cnt_q      <= '0;
            target_q   <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            wr_err_q   <= 1'b0;
            for (int b = 0; b < BANKS; b++) begin
                valid_q[b] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_bank_q <= clr_bank_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_en;
            hit_q      <= rd_en && rd_hit_d;
            target_q   <= rd_en ? rd_data_d : '0;
            wr_err_q   <= wr_rej;
            // Writes never target the bank under sweep, so these cannot collide.
            if (busy) begin
                valid_q[clr_bank_q][cnt_q] <= 1'b0;
            end
            if (wr_ok) begin
                valid_q[wr_bank][wr_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign target   = target_q;
    assign rd_valid = rd_valid_q;
    assign hit      = hit_q;
    assign wr_err   = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_target_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_target_table
// Brief    : Directed self-checking bench for pc_target_table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_target_table;

    localparam int D = 12;
    localparam int A = 5;
    localparam int BANKS = 2;
    localparam int B = 1;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         rd_en;
    logic [B-1:0] bank_sel;
    logic [A-1:0] addr;
    logic [D-1:0] target;
    logic         rd_valid;
    logic         hit;
    logic         wr_en;
    logic [B-1:0] wr_bank;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         wr_err;
    logic         clr_req;
    logic [B-1:0] clr_bank;
    logic         busy;
    logic         clr_done;

    int tests = 0;
    int fails = 0;

    pc_target_table #(.D(D), .A(A), .BANKS(BANKS)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .rd_en    (rd_en),
        .bank_sel (bank_sel),
        .addr     (addr),
        .target   (target),
        .rd_valid (rd_valid),
        .hit      (hit),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .clr_req  (clr_req),
        .clr_bank (clr_bank),
        .busy     (busy),
        .clr_done (clr_done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int b, input int a, input int d);
        wr_en   = 1'b1;
        wr_bank = B'(b);
        wr_addr = A'(a);
        wr_data = D'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input int b, input int a,
                           input int exp_t, input logic exp_h);
        rd_en    = 1'b1;
        bank_sel = B'(b);
        addr     = A'(a);
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk({tag, "_hit"}, 32'(hit), 32'(exp_h));
        chk({tag, "_tgt"}, 32'(target), 32'(exp_t));
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int hits;

        Reset = 1'b1; rd_en = 1'b0; bank_sel = '0; addr = '0;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        clr_req = 1'b0; clr_bank = '0;
        tick();
        tick();
        chk("rst_vld",  32'(rd_valid), 32'd0);
        chk("rst_hit",  32'(hit),      32'd0);
        chk("rst_tgt",  32'(target),   32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        chk("rst_err",  32'(wr_err),   32'd0);
        Reset = 1'b0;
        tick();

        do_read("empty_b0a3", 0, 3, 0, 1'b0);
        tick();
        chk("idle_vld", 32'(rd_valid), 32'd0);
        chk("idle_hit", 32'(hit),      32'd0);

        do_write(0, 1, 9);
        do_write(0, 3, 48);
        do_write(0, 14, 96);
        do_read("b0a3",  0, 3, 48, 1'b1);
        do_read("b0a14", 0, 14, 96, 1'b1);
        do_read("b0a1",  0, 1, 9, 1'b1);
        do_read("b1a3",  1, 3, 0, 1'b0);

        // Simultaneous write and read of the same entry
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 5'd7; wr_data = 12'd68;
        rd_en = 1'b1; bank_sel = 1'b0; addr = 5'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("byp_hit", 32'(hit),    32'd1);
        chk("byp_tgt", 32'(target), 32'd68);

        do_write(0, 0, 5);
        chk("a0_err", 32'(wr_err), 32'd0);
        do_read("b0a0", 0, 0, 0, 1'b0);

        for (int b = 0; b < 2; b++) begin
            for (int a = 1; a < 32; a++) begin
                do_write(b, a, (b << 8) | a);
            end
        end

        clr_req = 1'b1; clr_bank = 1'b0;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                chk("done_cycle", 32'(k), 32'd32);
            end
            if (k == 2) begin
                rd_en = 1'b1; bank_sel = 1'b0; addr = 5'd31;
            end
            if (k == 3) begin
                wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 5'd2; wr_data = 12'd123;
            end
            if (k == 5) begin
                wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 5'd5; wr_data = 12'd77;
            end
            tick();
            rd_en = 1'b0; wr_en = 1'b0;
            if (k == 2) begin
                chk("sweep_old_hit", 32'(hit),    32'd1);
                chk("sweep_old_tgt", 32'(target), 32'd31);
            end
            if (k == 3) chk("sweep_wr_b0_err", 32'(wr_err), 32'd1);
            if (k == 5) chk("sweep_wr_b1_err", 32'(wr_err), 32'd0);
        end
        chk("sweep1_busy_len", 32'(busy_cnt), 32'd32);
        chk("sweep1_done_cnt", 32'(done_cnt), 32'd1);

        hits = 0;
        for (int a = 1; a < 32; a++) begin
            rd_en = 1'b1; bank_sel = 1'b0; addr = A'(a);
            tick();
            if (hit) hits++;
        end
        rd_en = 1'b0;
        chk("b0_after_clear_hits", 32'(hits), 32'd0);
        do_read("b1a5_new", 1, 5, 77, 1'b1);
        do_read("b1a9",  1, 9,  (1 << 8) | 9,  1'b1);
        do_read("b1a31", 1, 31, (1 << 8) | 31, 1'b1);
        hits = 0;
        for (int a = 1; a < 32; a++) begin
            rd_en = 1'b1; bank_sel = 1'b1; addr = A'(a);
            tick();
            if (hit) hits++;
        end
        rd_en = 1'b0;
        chk("b1_kept_hits", 32'(hits), 32'd31);

        // Reset partway through a sweep of bank 1
        clr_req = 1'b1; clr_bank = 1'b1;
        tick();
        clr_req = 1'b0;
        done_cnt = 0;
        for (int k = 1; k < 10; k++) begin
            if (clr_done) done_cnt++;
            tick();
        end
        chk("abort_busy_c10", 32'(busy), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_busy", 32'(busy),     32'd0);
        chk("abort_done", 32'(clr_done), 32'd0);
        chk("abort_no_early_done", 32'(done_cnt), 32'd0);
        hits = 0;
        for (int b = 0; b < 2; b++) begin
            for (int a = 1; a < 32; a++) begin
                rd_en = 1'b1; bank_sel = B'(b); addr = A'(a);
                tick();
                if (hit) hits++;
            end
        end
        rd_en = 1'b0;
        chk("abort_all_miss", 32'(hits), 32'd0);

        // New request from IDLE, with a second request mid-sweep
        clr_req = 1'b1; clr_bank = 1'b0;
        tick();
        clr_req = 1'b0;
        chk("reclear_busy", 32'(busy), 32'd1);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            if (busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (k == 4) begin
                clr_req = 1'b1; clr_bank = 1'b1;
            end
            tick();
            clr_req = 1'b0;
        end
        chk("sweep2_busy_len", 32'(busy_cnt), 32'd32);
        chk("sweep2_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
